// File: rtl/aes128_rr_scheduler.sv
// Round-robin front end for a single shared AES-128 encryption core.
// Grants one requester at a time, latches its plaintext/key, runs the core
// through its reset/ce start sequence under a watchdog, and returns the
// ciphertext tagged with the requester ID on a valid/ready response port.
module aes128_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_data,
  input  logic [NUM_REQ*128-1:0]   req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [127:0]             rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     core_reset,
  output logic                     core_ce,
  output logic [127:0]             core_data_in,
  output logic [127:0]             core_key,
  input  logic [127:0]             core_data_out,
  input  logic                     core_done
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] scan_idx;
  logic            grant_vld;
  logic [TMR_W-1:0] timer;
  logic            run_done;
  logic            run_tmo;

  // Pick the first active requester after the one served last, wrapping around
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  // Accept is only offered in IDLE and never while reset is held
  always_comb begin
    req_ready = '0;
    if (reset && (state == S_IDLE) && grant_vld) req_ready[grant] = 1'b1;
  end

  // Core completion beats the watchdog when both land in the same cycle
  always_comb begin
    run_done  = (state == S_RUN) && core_done;
    run_tmo   = (state == S_RUN) && !core_done && (timer == TMR_W'(TIMEOUT - 1));
    state_nxt = state;
    case (state)
      S_IDLE: if (grant_vld) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_RUN;
      S_RUN:  if (run_done || run_tmo) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Control state; core strobes are registered from the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      timer      <= '0;
      core_reset <= 1'b1;
      core_ce    <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_reset <= (state_nxt == S_LOAD);
      core_ce    <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      if ((state == S_IDLE) && grant_vld) last_grant <= grant;
      if (state == S_LOAD)     timer <= '0;
      else if (state == S_RUN) timer <= timer + 1'b1;
      if (run_done || run_tmo)                rsp_valid <= 1'b1;
      else if ((state == S_RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  // Operand latch at grant and result capture at the end of RUN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_data_in <= '0;
      core_key     <= '0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && grant_vld) begin
        core_data_in <= req_data[grant*128 +: 128];
        core_key     <= req_key[grant*128 +: 128];
        rsp_id       <= grant;
      end
      if (run_done) begin
        rsp_data  <= core_data_out;
        rsp_error <= 1'b0;
      end else if (run_tmo) begin
        rsp_data  <= '0;
        rsp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes128_rr_scheduler.sv
// Bench for aes128_rr_scheduler: behavioural core model plus directed and
// randomized request scenarios checked against a round-robin reference.
module tb_aes128_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int CORE_LAT = 45;

  logic                   clock;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_error;
  logic                   busy;
  logic                   core_reset;
  logic                   core_ce;
  logic [127:0]           core_data_in;
  logic [127:0]           core_key;
  logic [127:0]           core_data_out;
  logic                   core_done;

  int errors = 0;
  int checks = 0;
  int model_last;
  logic stuck = 1'b0;
  int core_cnt = 0;

  logic [127:0] vec_key [5] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'h2b7e151628aed2a6abf7158809cf4f3c};
  logic [127:0] vec_pt [5] = '{
    128'h00112233445566778899aabbccddeeff,
    128'h3243f6a8885a308d313198a2e0370734,
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef};
  logic [127:0] vec_ct [5] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'h3925841d02dc09fbdc118597196a0b32,
    128'h3ad77bb40d7a3660a89ecaf32466ef97,
    128'hf5d3d58503b9699de785895a96fdbaaf,
    128'h43b1cd7f598ece23881b00e3ed030688};

  aes128_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_error(rsp_error), .busy(busy), .core_reset(core_reset),
    .core_ce(core_ce), .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .core_done(core_done));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Known-answer AES for the test vectors; a stand-in mixing for other operands
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    for (int i = 0; i < 5; i++)
      if (pt == vec_pt[i] && key == vec_key[i]) return vec_ct[i];
    return pt ^ {key[63:0], key[127:64]} ^ 128'hc3a5_5a3c_0f1e_2d4b_9687_7869_f0e1_d2c3;
  endfunction

  // Core model: synchronous active-high reset, result after CORE_LAT enabled cycles
  always @(posedge clock) begin
    if (core_reset) core_cnt <= 0;
    else if (core_ce && core_cnt < 200) core_cnt <= core_cnt + 1;
  end
  assign core_done     = !stuck && (core_cnt >= CORE_LAT);
  assign core_data_out = core_done ? aes_ref(core_data_in, core_key) : 128'h0;

  // Reference arbiter: rotate the requester list to start after the last winner
  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
    int order[$];
    for (int i = 0; i < NUM_REQ; i++) order.push_back(i);
    while (order[0] != (last + 1) % NUM_REQ) order.push_back(order.pop_front());
    foreach (order[k]) if (mask[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
    req_data[i*128 +: 128] = pt;
    req_key[i*128 +: 128]  = key;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    stuck = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_last = NUM_REQ - 1;
    @(negedge clock);
  endtask

  task automatic wait_grant(output logic [NUM_REQ-1:0] rdy);
    rdy = '0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready != 0) begin
        rdy = req_ready;
        return;
      end
      @(negedge clock);
    end
    checks++; errors++;
    $display("FAIL grant_timeout: req_ready stayed 0 for 100 cycles, required a grant");
  endtask

  // Count rising edges until rsp_valid is seen high
  task automatic wait_rsp(output int edges);
    edges = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clock);
      #1;
      edges++;
      if (rsp_valid) return;
    end
    checks++; errors++;
    $display("FAIL rsp_timeout: rsp_valid stayed 0 for 300 edges, required 1");
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_data = '0;
    req_key = '0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b need 0", rsp_valid); end
    checks++; if (rsp_data !== 128'h0) begin errors++; $display("FAIL rst_rsp_data: got %h need 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0 || rsp_error !== 1'b0) begin errors++; $display("FAIL rst_rsp_id_err: got %0d/%b need 0/0", rsp_id, rsp_error); end
    checks++; if (core_reset !== 1'b1 || core_ce !== 1'b0) begin errors++; $display("FAIL rst_core_ctl: got reset=%b ce=%b need 1/0", core_reset, core_ce); end
    checks++; if (core_data_in !== 128'h0 || core_key !== 128'h0) begin errors++; $display("FAIL rst_core_ops: got %h %h need 0", core_data_in, core_key); end
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_ready_busy: got %b/%b need 0000/0", req_ready, busy); end
    req_valid = '0;
    reset = 1'b1;
    model_last = NUM_REQ - 1;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] rdy;
    int edges;
    apply_reset();
    set_req(0, vec_pt[0], vec_key[0]);
    req_valid = 4'b0001;
    wait_grant(rdy);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b need 0001", rdy); end
    @(posedge clock); #1;
    req_valid = '0;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_once: got %b need 0000", req_ready); end
    checks++; if (core_reset !== 1'b1 || core_ce !== 1'b1) begin errors++; $display("FAIL single_load_ctl: got %b/%b need 1/1", core_reset, core_ce); end
    checks++; if (core_data_in !== vec_pt[0] || core_key !== vec_key[0]) begin errors++; $display("FAIL single_latch: got %h %h", core_data_in, core_key); end
    wait_rsp(edges);
    checks++; if (edges !== 47) begin errors++; $display("FAIL single_latency: got %0d edges need 47", edges); end
    checks++; if (rsp_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL single_data: got %h need 69c4e0d86a7b0430d8cdb78070b4c55a", rsp_data); end
    checks++; if (rsp_id !== 2'd0 || rsp_error !== 1'b0) begin errors++; $display("FAIL single_id_err: got %0d/%b need 0/0", rsp_id, rsp_error); end
    checks++; if (core_data_in !== vec_pt[0] || core_key !== vec_key[0]) begin errors++; $display("FAIL single_hold: got %h %h", core_data_in, core_key); end
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got valid=%b busy=%b need 0/0", rsp_valid, busy); end
    @(negedge clock);
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] rdy;
    int edges, exp;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, vec_pt[i], vec_key[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = rr_pick(req_valid, model_last);
      wait_grant(rdy);
      checks++; if (rdy !== 4'(1 << exp)) begin errors++; $display("FAIL rr_grant%0d: got %b need id %0d", k, rdy, exp); end
      @(posedge clock); #1;
      wait_rsp(edges);
      checks++; if (rsp_id !== 2'(exp) || rsp_data !== vec_ct[exp]) begin errors++; $display("FAIL rr_rsp%0d: got id %0d data %h need id %0d data %h", k, rsp_id, rsp_data, exp, vec_ct[exp]); end
      model_last = exp;
      if (k == 4) req_valid = '0;
      @(posedge clock); #1;
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] rdy, mask;
    logic [127:0] pt [NUM_REQ];
    logic [127:0] ky [NUM_REQ];
    int edges, exp, stall;
    apply_reset();
    for (int it = 0; it < 10; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        pt[i] = {$urandom, $urandom, $urandom, $urandom};
        ky[i] = {$urandom, $urandom, $urandom, $urandom};
        set_req(i, pt[i], ky[i]);
      end
      exp = rr_pick(mask, model_last);
      rsp_ready = 1'b0;
      req_valid = mask;
      wait_grant(rdy);
      checks++; if (rdy !== 4'(1 << exp)) begin errors++; $display("FAIL rand_grant%0d: got %b need id %0d mask %b", it, rdy, exp, mask); end
      @(posedge clock); #1;
      req_valid = 4'($urandom);
      wait_rsp(edges);
      checks++; if (edges !== 47 || rsp_id !== 2'(exp) || rsp_data !== aes_ref(pt[exp], ky[exp]) || rsp_error !== 1'b0)
        begin errors++; $display("FAIL rand_rsp%0d: got edges %0d id %0d data %h err %b need 47 %0d %h 0", it, edges, rsp_id, rsp_data, rsp_error, exp, aes_ref(pt[exp], ky[exp])); end
      model_last = exp;
      stall = $urandom_range(0, 5);
      for (int s = 0; s < stall; s++) @(negedge clock);
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp)) begin errors++; $display("FAIL rand_stall%0d: got valid %b id %0d need 1 %0d", it, rsp_valid, rsp_id, exp); end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] rdy;
    logic [127:0] pt, ky;
    int edges;
    apply_reset();
    pt = {$urandom, $urandom, $urandom, $urandom};
    ky = {$urandom, $urandom, $urandom, $urandom};
    set_req(2, pt, ky);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    wait_grant(rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b need 0100", rdy); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_rsp(edges);
    req_valid = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== aes_ref(pt, ky) || rsp_id !== 2'd2 || core_ce !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d: got valid %b data %h id %0d ce %b ready %b busy %b", c, rsp_valid, rsp_data, rsp_id, core_ce, req_ready, busy); end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %b busy %b need 0/0", rsp_valid, busy); end
    @(negedge clock);
  endtask

  task automatic test_watchdog();
    logic [NUM_REQ-1:0] rdy;
    int edges;
    apply_reset();
    stuck = 1'b1;
    set_req(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    req_valid = 4'b0010;
    wait_grant(rdy);
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL wd_grant: got %b need 0010", rdy); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_rsp(edges);
    checks++; if (edges !== TIMEOUT + 1) begin errors++; $display("FAIL wd_latency: got %0d edges need %0d", edges, TIMEOUT + 1); end
    checks++; if (rsp_error !== 1'b1 || rsp_data !== 128'h0 || rsp_id !== 2'd1) begin errors++; $display("FAIL wd_rsp: got err %b data %h id %0d need 1 0 1", rsp_error, rsp_data, rsp_id); end
    @(posedge clock); #1;
    stuck = 1'b0;
    @(negedge clock);
    set_req(3, vec_pt[4], vec_key[4]);
    req_valid = 4'b1000;
    wait_grant(rdy);
    checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL wd_next_grant: got %b need 1000", rdy); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_rsp(edges);
    checks++; if (edges !== 47 || rsp_error !== 1'b0 || rsp_data !== vec_ct[4] || rsp_id !== 2'd3)
      begin errors++; $display("FAIL wd_next_rsp: got edges %0d err %b data %h id %0d", edges, rsp_error, rsp_data, rsp_id); end
    @(posedge clock); #1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [NUM_REQ-1:0] rdy;
    int edges;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, vec_pt[i], vec_key[i]);
    req_valid = 4'b0001;
    wait_grant(rdy);
    @(posedge clock); #1;
    req_valid = '0;
    repeat (11) @(posedge clock);
    #2;
    req_valid = 4'b1100;
    reset = 1'b0;
    #1;
    checks++; if (core_reset !== 1'b1 || core_ce !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL midrst_async: got creset %b ce %b valid %b busy %b ready %b", core_reset, core_ce, rsp_valid, busy, req_ready); end
    @(negedge clock);
    reset = 1'b1;
    model_last = NUM_REQ - 1;
    wait_grant(rdy);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL midrst_first: got %b need 0100", rdy); end
    @(posedge clock); #1;
    req_valid = 4'b1000;
    wait_rsp(edges);
    checks++; if (rsp_id !== 2'd2 || rsp_data !== vec_ct[2]) begin errors++; $display("FAIL midrst_rsp2: got id %0d data %h need 2 %h", rsp_id, rsp_data, vec_ct[2]); end
    @(posedge clock); #1;
    wait_grant(rdy);
    checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL midrst_second: got %b need 1000", rdy); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_rsp(edges);
    checks++; if (rsp_id !== 2'd3 || rsp_data !== vec_ct[3]) begin errors++; $display("FAIL midrst_rsp3: got id %0d data %h need 3 %h", rsp_id, rsp_data, vec_ct[3]); end
    @(posedge clock); #1;
    @(negedge clock);
  endtask

  task automatic test_late_drop();
    logic [NUM_REQ-1:0] rdy;
    int edges, bad;
    apply_reset();
    set_req(0, vec_pt[1], vec_key[1]);
    set_req(1, vec_pt[2], vec_key[2]);
    req_valid = 4'b0001;
    wait_grant(rdy);
    @(posedge clock); #1;
    req_valid = '0;
    repeat (10) @(negedge clock);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_ready: got %b need 0000", req_ready); end
    @(negedge clock);
    req_valid = '0;
    wait_rsp(edges);
    checks++; if (rsp_id !== 2'd0 || rsp_data !== vec_ct[1]) begin errors++; $display("FAIL drop_rsp: got id %0d data %h need 0 %h", rsp_id, rsp_data, vec_ct[1]); end
    @(posedge clock); #1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL drop_spurious: got %0d active cycles need 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_late_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
